// File: rtl/fifo_pkg.sv
// Shared defaults and the read-client state type for the team's synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_WIDTH     = 16;
    localparam int FIFO_BUF_DEPTH = 2;

    typedef enum logic {
        S_IDLE,
        S_CAPT
    } rd_state_t;

    // Occupancy counters need one extra bit so a full buffer is distinguishable from empty.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Small circular output buffer for fifo_reader: push at the tail, pop at the head.
module fifo_reader_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_BUF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_push_data,
    input  logic                        i_pop,
    output logic [occ_width(DEPTH)-1:0] o_occ,
    output logic [WIDTH-1:0]            o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_pop;

    assign w_pop = i_pop && (r_occ != '0);

    // NOTE: state updates use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; o_head is forced to zero while empty instead.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_occ  = r_occ;
    assign o_head = (r_occ != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fifo_reader.sv
// Read-side client of the synchronous FIFO; re-presents popped words on a valid/ready stream.
// Define FIFO_READER_CNT_EN to add the 16-bit rd_count delivery counter port.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int BUF_DEPTH = FIFO_BUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_,
    output logic             fifo_read,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic             fifo_write,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [15:0]      rd_count
`endif
);

    localparam int OCC_W = occ_width(BUF_DEPTH);
    localparam int CRD_W = OCC_W + 1;

    rd_state_t        r_state;
    logic [OCC_W-1:0] w_occ;
    logic [CRD_W-1:0] w_credit;
    logic             w_capture;
    logic             w_deq;
    logic             w_pop_ok;

    assign w_capture = (r_state == S_CAPT);
    assign w_deq     = out_valid && out_ready;

    // Slots committed after this edge: stored words plus the one in flight, minus the one leaving.
    assign w_credit  = CRD_W'(w_occ) + CRD_W'(w_capture) - CRD_W'(w_deq);
    assign fifo_read = !fifo_empty && (w_credit < CRD_W'(BUF_DEPTH));

    // The FIFO silently drops a read that coincides with an unblocked write.
    assign w_pop_ok  = fifo_read && !fifo_empty && !(fifo_write && !fifo_full);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= w_pop_ok ? S_CAPT : S_IDLE;
                S_CAPT:  r_state <= w_pop_ok ? S_CAPT : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    fifo_reader_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst_        (rst_),
        .i_push      (w_capture),
        .i_push_data (fifo_data_out),
        .i_pop       (w_deq),
        .o_occ       (w_occ),
        .o_head      (out_data)
    );

    assign out_valid = (w_occ != '0);

`ifdef FIFO_READER_CNT_EN
    logic [15:0] r_rd_count;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)      r_rd_count <= 16'd0;
        else if (w_deq) r_rd_count <= r_rd_count + 16'd1;
    end

    assign rd_count = r_rd_count;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_)
        !(w_capture && (w_occ == OCC_W'(BUF_DEPTH)) && !w_deq));

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a queue-based FIFO model feeds the DUT, a monitor checks delivery order.
module tb_fifo_reader;

    localparam int WIDTH     = 16;
    localparam int BUF_DEPTH = 2;
    localparam int FIFO_CAP  = 16;

    logic             clk        = 1'b0;
    logic             rst_       = 1'b0;
    logic             fifo_read;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_write = 1'b0;
    logic [WIDTH-1:0] fifo_data_out = '0;
    logic [WIDTH-1:0] wr_data    = '0;
    logic             out_valid;
    logic             out_ready  = 1'b0;
    logic [WIDTH-1:0] out_data;
`ifdef FIFO_READER_CNT_EN
    logic [15:0]      rd_count;
`endif

    logic             src_mode   = 1'b0;
    logic             full_ovr   = 1'b0;
    logic [WIDTH-1:0] src_next   = 16'h8000;
    int               fq_n       = 0;
    int               cyc        = 0;
    int               n_chk      = 0;
    int               n_fail     = 0;
    int               n_deq      = 0;
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] deq_dat[$];
    int               pop_log[$];
    int               deq_log[$];

    fifo_reader #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .fifo_read     (fifo_read),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_write    (fifo_write),
        .fifo_data_out (fifo_data_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data)
`ifdef FIFO_READER_CNT_EN
        ,
        .rd_count      (rd_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source mode models an endless FIFO handing out consecutive words.
    assign fifo_empty = !src_mode && (fq_n == 0);
    assign fifo_full  = full_ovr || (fq_n >= FIFO_CAP);

    // FIFO model: accepted writes define the expected delivery order.
    always @(posedge clk or negedge rst_) begin : fifo_model
        logic pop;
        logic wr;
        if (!rst_) begin
            fq.delete();
            exp_q.delete();
            fq_n          <= 0;
            fifo_data_out <= '0;
        end else begin
            pop = fifo_read && !fifo_empty && !(fifo_write && !fifo_full);
            wr  = fifo_write && !fifo_full;
            if (pop) begin
                pop_log.push_back(cyc);
                if (src_mode) begin
                    fifo_data_out <= src_next;
                    exp_q.push_back(src_next);
                    src_next      <= src_next + 16'd1;
                end else begin
                    fifo_data_out <= fq.pop_front();
                end
            end
            if (wr) begin
                fq.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            fq_n <= fq.size();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [WIDTH-1:0] e;
        if (!rst_) begin
            n_deq = 0;
        end else if (out_valid && out_ready) begin
            deq_log.push_back(cyc);
            deq_dat.push_back(out_data);
            n_deq++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_extra: got %0h, expected no word (cycle %0d)", out_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("sb_order", 32'(out_data), 32'(e));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [WIDTH-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_write = 1'b1;
            wr_data    = base + 16'(i);
            step();
        end
        fifo_write = 1'b0;
    endtask

    task automatic wait_deq(input int target, input int budget, input string name);
        int k = 0;
        while (deq_log.size() < target && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(deq_log.size()), 32'(target));
    endtask

    task automatic drain(input string name);
        int k = 0;
        fifo_write = 1'b0;
        full_ovr   = 1'b0;
        out_ready  = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && k < 300) begin
            step();
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : driver
        int i0;
        int d0;
        int c0;

        // Reset state
        step(3);
        check("rst_fifo_read", 32'(fifo_read), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
`ifdef FIFO_READER_CNT_EN
        check("rst_rd_count",  32'(rd_count),  32'd0);
`endif
        rst_ = 1'b1;
        check("rst_release_valid", 32'(out_valid), 32'd0);
        step();

        // Basic order and latency
        out_ready = 1'b1;
        i0 = pop_log.size();
        d0 = deq_log.size();
        push_words(16'h0001, 4);
        wait_deq(d0 + 4, 30, "basic_count");
        check("basic_pops", 32'(pop_log.size() - i0), 32'd4);
        if (deq_log.size() >= d0 + 4 && pop_log.size() > i0) begin
            check("basic_latency",    32'(deq_log[d0] - pop_log[i0]), 32'd2);
            check("basic_back2back",  32'(deq_log[d0+3] - deq_log[d0]), 32'd3);
            check("basic_first_word", 32'(deq_dat[d0]), 32'h0001);
        end
        step(2);

        // Backpressure: only BUF_DEPTH pops while the consumer stalls
        out_ready = 1'b0;
        i0 = pop_log.size();
        push_words(16'h0100, 8);
        step(6);
        check("bp_pops",      32'(pop_log.size() - i0), 32'(BUF_DEPTH));
        check("bp_read_low",  32'(fifo_read), 32'd0);
        check("bp_valid",     32'(out_valid), 32'd1);
        check("bp_head",      32'(out_data),  32'h0100);
        d0 = deq_log.size();
        out_ready = 1'b1;
        wait_deq(d0 + 8, 40, "bp_drain");
        step(2);

        // Write collision: read is dropped, retried next cycle
        i0 = pop_log.size();
        d0 = deq_log.size();
        fifo_write = 1'b1;
        wr_data    = 16'h0200;
        step();
        wr_data    = 16'h0201;
        check("coll_read_req", 32'(fifo_read), 32'd1);
        step();
        check("coll_no_pop", 32'(pop_log.size() - i0), 32'd0);
        fifo_write = 1'b0;
        c0 = cyc;
        step();
        check("coll_retry", 32'(pop_log.size() - i0), 32'd1);
        if (pop_log.size() > i0) check("coll_retry_cyc", 32'(pop_log[i0]), 32'(c0));
        check("coll_idle", 32'(out_valid), 32'd0);
        wait_deq(d0 + 2, 20, "coll_deliver");
        step(2);

        // Full FIFO: a blocked write does not block the read
        d0 = deq_log.size();
        push_words(16'h0300, 1);
        i0 = pop_log.size();
        c0 = cyc;
        full_ovr   = 1'b1;
        fifo_write = 1'b1;
        wr_data    = 16'hDEAD;
        step();
        full_ovr   = 1'b0;
        fifo_write = 1'b0;
        check("full_pop", 32'(pop_log.size() - i0), 32'd1);
        wait_deq(d0 + 1, 10, "full_deliver");
        if (deq_log.size() > d0) check("full_latency", 32'(deq_log[d0] - c0), 32'd2);
        step(2);

        // Reset mid-stream with a full buffer and words still in the FIFO
        out_ready = 1'b0;
        push_words(16'h0400, 5);
        step(4);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_ = 1'b0;
        #1;
        check("midrst_valid",     32'(out_valid), 32'd0);
        check("midrst_data",      32'(out_data),  32'd0);
        check("midrst_fifo_read", 32'(fifo_read), 32'd0);
`ifdef FIFO_READER_CNT_EN
        check("midrst_rd_count",  32'(rd_count),  32'd0);
`endif
        step(2);
        rst_ = 1'b1;
        check("midrst_release_valid", 32'(out_valid), 32'd0);
        step();
        check("midrst_first_cycle_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        d0 = deq_log.size();
        push_words(16'h00A0, 3);
        wait_deq(d0 + 3, 20, "restart_count");
        if (deq_log.size() > d0) check("restart_word", 32'(deq_dat[d0]), 32'h00A0);
        step(2);

        // Randomized writes, stalls and full flags
        for (int i = 0; i < 2000; i++) begin
            fifo_write = ($urandom_range(0, 99) < 40);
            wr_data    = 16'($urandom);
            out_ready  = ($urandom_range(0, 99) < 70);
            full_ovr   = ($urandom_range(0, 99) < 5);
            step();
        end
        drain("rand_drain");

`ifdef FIFO_READER_CNT_EN
        // Counter wrap: 65537 deliveries from a clean reset
        rst_ = 1'b0;
        step(2);
        rst_ = 1'b1;
        step();
        src_mode  = 1'b1;
        out_ready = 1'b1;
        begin
            int k = 0;
            while (n_deq < 65537 && k < 70000) begin
                step();
                k++;
            end
        end
        out_ready = 1'b0;
        check("cnt_deliveries", 32'(n_deq), 32'd65537);
        check("cnt_wrap", 32'(rd_count), 32'd1);
        src_mode = 1'b0;
        drain("cnt_drain");
        check("cnt_final", 32'(rd_count), 32'(n_deq & 32'hFFFF));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
